// File: rtl/ais_hdlc_framer.sv
// AIS/HDLC transmit framer: training preamble, start flag, LSB-first bit-stuffed payload,
// CRC-16 FCS and end flag, optionally NRZI-encoded, one bit per output handshake.
module ais_hdlc_framer #(
    parameter int unsigned PAR_PREAMBLE_LEN = 24,
    parameter bit          PAR_NRZI         = 1'b1,
    parameter logic [7:0]  PAR_FLAG         = 8'h7E
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tlast,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tdata,
    output logic       m_axis_tlast,
    output logic       o_busy,
    output logic       o_underrun
);

    localparam logic [5:0]  LP_PRE_LAST = 6'(PAR_PREAMBLE_LEN - 1);
    localparam logic [15:0] LP_CRC_INIT = 16'hFFFF;
    localparam logic [15:0] LP_CRC_POLY = 16'h8408;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFLAG,
        ST_PAYLOAD,
        ST_FCS,
        ST_EFLAG
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [7:0]  r_sr;
    logic [3:0]  r_bits;
    logic        r_last;
    logic [15:0] r_crc;
    logic [2:0]  r_ones;
    logic        r_level;
    logic        r_tvalid;
    logic        r_tdata;
    logic        r_tlast;
    logic        r_underrun;
    logic        r_starved;

    logic        w_adv;
    logic        w_ready;
    logic        w_accept;
    logic        w_stuff;
    logic [7:0]  w_byte;
    logic        w_byte_last;
    logic [3:0]  w_byte_bits;
    logic        w_have;
    logic        w_starve;
    logic        w_emit;
    logic        w_raw;
    logic        w_tlast;
    logic [2:0]  w_ones_next;
    logic [15:0] w_crc_next;
    logic        w_level;
    logic        w_line;

    // When the shift register is empty the byte being accepted is used directly,
    // so byte boundaries cost no bubble at one bit per cycle.
    always_comb begin
        // NOTE: every w_ signal gets a value before the case below, so no latch is inferred.
        w_adv       = !r_tvalid || m_axis_tready;
        w_ready     = (r_state == ST_PAYLOAD) && (r_bits == 4'd0);
        w_accept    = w_ready && s_axis_tvalid;
        w_stuff     = (r_ones == 3'd5);
        w_byte      = (r_bits == 4'd0) ? s_axis_tdata : r_sr;
        w_byte_last = (r_bits == 4'd0) ? s_axis_tlast : r_last;
        w_byte_bits = (r_bits == 4'd0) ? 4'd8 : r_bits;
        w_have      = (r_bits != 4'd0) || w_accept;
        w_starve    = (r_state == ST_PAYLOAD) && w_adv && !w_stuff && (r_bits == 4'd0)
                      && !r_last && !s_axis_tvalid;
        w_emit      = 1'b0;
        w_raw       = 1'b0;
        w_tlast     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_emit = s_axis_tvalid;
            end
            ST_PREAMBLE: begin
                w_emit = w_adv;
            end
            ST_SFLAG: begin
                w_emit = w_adv;
                w_raw  = PAR_FLAG[r_cnt[2:0]];
            end
            ST_PAYLOAD: begin
                w_emit = w_adv && (w_stuff || w_have);
                w_raw  = !w_stuff && w_byte[0];
            end
            ST_FCS: begin
                w_emit = w_adv && (w_stuff || (r_cnt < 6'd16));
                w_raw  = !w_stuff && !r_crc[r_cnt[3:0]];
            end
            ST_EFLAG: begin
                w_emit  = w_adv && (r_cnt < 6'd8);
                w_raw   = PAR_FLAG[r_cnt[2:0]];
                w_tlast = (r_cnt == 6'd7);
            end
            default: begin
                w_emit = 1'b0;
            end
        endcase
        w_ones_next = w_raw ? r_ones + 3'd1 : 3'd0;
        w_crc_next  = {1'b0, r_crc[15:1]} ^ ((r_crc[0] ^ w_byte[0]) ? LP_CRC_POLY : 16'h0000);
        // The line level restarts at 0 for every frame, so the first preamble bit is a 1.
        w_level     = (r_state == ST_IDLE) ? 1'b0 : r_level;
        w_line      = PAR_NRZI ? (w_raw ? w_level : !w_level) : w_raw;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 6'd0;
            r_sr       <= 8'd0;
            r_bits     <= 4'd0;
            r_last     <= 1'b0;
            r_crc      <= LP_CRC_INIT;
            r_ones     <= 3'd0;
            r_level    <= 1'b0;
            r_tvalid   <= 1'b0;
            r_tdata    <= 1'b0;
            r_tlast    <= 1'b0;
            r_underrun <= 1'b0;
            r_starved  <= 1'b0;
        end else begin
            // NOTE: non-blocking only; the comb block above must see this cycle's values.
            r_underrun <= w_starve && !r_starved;
            if (w_starve) begin
                r_starved <= 1'b1;
            end else if (w_accept) begin
                r_starved <= 1'b0;
            end

            if (w_adv) begin
                r_tvalid <= w_emit;
                r_tdata  <= w_emit && w_line;
                r_tlast  <= w_emit && w_tlast;
                if (w_emit) begin
                    r_level <= w_line;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    r_crc  <= LP_CRC_INIT;
                    r_ones <= 3'd0;
                    r_bits <= 4'd0;
                    r_last <= 1'b0;
                    if (s_axis_tvalid) begin
                        if (PAR_PREAMBLE_LEN == 1) begin
                            r_state <= ST_SFLAG;
                            r_cnt   <= 6'd0;
                        end else begin
                            r_state <= ST_PREAMBLE;
                            r_cnt   <= 6'd1;
                        end
                    end
                end
                ST_PREAMBLE: begin
                    if (w_emit) begin
                        if (r_cnt == LP_PRE_LAST) begin
                            r_state <= ST_SFLAG;
                            r_cnt   <= 6'd0;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                end
                ST_SFLAG: begin
                    if (w_emit) begin
                        if (r_cnt == 6'd7) begin
                            r_state <= ST_PAYLOAD;
                            r_cnt   <= 6'd0;
                            r_crc   <= LP_CRC_INIT;
                            r_ones  <= 3'd0;
                            r_bits  <= 4'd0;
                            r_last  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_emit && w_stuff) begin
                        r_ones <= 3'd0;
                        if (w_accept) begin
                            r_sr   <= s_axis_tdata;
                            r_bits <= 4'd8;
                            r_last <= s_axis_tlast;
                        end
                    end else if (w_emit) begin
                        r_crc  <= w_crc_next;
                        r_ones <= w_ones_next;
                        r_sr   <= {1'b0, w_byte[7:1]};
                        r_bits <= w_byte_bits - 4'd1;
                        r_last <= w_byte_last;
                        if ((w_byte_bits == 4'd1) && w_byte_last) begin
                            r_state <= ST_FCS;
                            r_cnt   <= 6'd0;
                        end
                    end else if (w_accept) begin
                        r_sr   <= s_axis_tdata;
                        r_bits <= 4'd8;
                        r_last <= s_axis_tlast;
                    end
                end
                ST_FCS: begin
                    // r_cnt == 16 means all FCS bits are out but a stuffed 0 is still owed.
                    if (w_emit) begin
                        if (w_stuff) begin
                            r_ones <= 3'd0;
                            if (r_cnt == 6'd16) begin
                                r_state <= ST_EFLAG;
                                r_cnt   <= 6'd0;
                            end
                        end else begin
                            r_ones <= w_ones_next;
                            if ((r_cnt == 6'd15) && (w_ones_next != 3'd5)) begin
                                r_state <= ST_EFLAG;
                                r_cnt   <= 6'd0;
                            end else begin
                                r_cnt <= r_cnt + 6'd1;
                            end
                        end
                    end
                end
                ST_EFLAG: begin
                    if (w_adv) begin
                        if (r_cnt == 6'd8) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= 6'd0;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axis_tready = w_ready;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tlast  = r_tlast;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_underrun    = r_underrun;

endmodule

// File: doc/ais_hdlc_framer.md
Name: ais_hdlc_framer

Overview:
- Transmit-side counterpart of the AIS frame detector.
- Takes payload bytes on an AXI-stream input and emits an AIS/HDLC bit stream: training preamble, start flag 0x7E, LSB-first bit-stuffed payload, CRC-16 FCS, end flag. Optional NRZI encoding.
- Feeds the GMSK modulator on the TX path, one bit per handshake.

Parameters:
- PAR_PREAMBLE_LEN, 24, number of training bits (raw 0s, which become an alternating pattern after NRZI); legal range 1..63.
- PAR_NRZI, 1, 1 = NRZI-encode output (raw 0 toggles the level, raw 1 holds it); 0 = emit raw bits.
- PAR_FLAG, 8'h7E, flag byte, sent LSB-first, never stuffed.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous, active-low reset
- s_axis_tvalid  in  1  payload byte valid
- s_axis_tready  out  1  payload byte accepted when tvalid && tready
- s_axis_tdata  in  8  payload byte
- s_axis_tlast  in  1  last payload byte of frame
- m_axis_tvalid  out  1  output bit valid
- m_axis_tready  in  1  modulator ready
- m_axis_tdata  out  1  output bit
- m_axis_tlast  out  1  high on the final end-flag bit
- o_busy  out  1  frame in progress (state != IDLE)
- o_underrun  out  1  one-cycle pulse when payload is starved

Behaviour:
- Reset is synchronous, active-low on i_clk. Reset state:
  - state IDLE; all outputs 0; NRZI level 0; CRC 16'hFFFF; ones counter 0.
  - Reset mid-frame aborts immediately; no end flag is sent.
- Output register rules:
  - m_axis_tdata/tlast change only when m_axis_tvalid=0 or m_axis_tready=1 (AXI hold rule).
  - Next-bit generation advances only on an output handshake or when the register is empty.
- FSM transitions:
  - IDLE -> PREAMBLE when s_axis_tvalid=1. The byte is not consumed yet. The first output bit is valid the next cycle.
  - PREAMBLE: emit PAR_PREAMBLE_LEN raw 0s, then go to SFLAG.
  - SFLAG: emit PAR_FLAG, 8 bits LSB-first, then go to PAYLOAD. Reset CRC to FFFF and ones counter to 0.
  - PAYLOAD:
    - 8-bit shift register plus a 4-bit bit count. s_axis_tready=1 only in PAYLOAD while the shift register is empty.
    - Bits are sent LSB-first. Each data bit (not stuffed bits) updates the CRC: reflected poly 0x8408, fb = crc[0]^bit, crc = (crc>>1) ^ (fb ? 0x8408 : 0).
    - After the byte taken with tlast has been fully sent, go to FCS.
  - FCS: send ~crc as 16 bits, LSB-first (low byte first). Stuffing applies; CRC is not updated. Then go to EFLAG.
  - EFLAG: emit PAR_FLAG unstuffed. m_axis_tlast=1 on bit 7. On its handshake go to IDLE.
  - A new frame may start on the cycle after returning to IDLE.
- Bit stuffing (PAYLOAD and FCS only):
  - Ones counter increments on each raw 1 and clears on any 0.
  - When it reaches 5, the next emitted bit is an inserted 0 and the counter clears. Data shifting pauses for that bit.
  - A stuffed bit is still inserted if the 5th 1 is the last FCS bit, before EFLAG.
- NRZI:
  - Applied after stuffing, to all states.
  - The level register is set to 0 on entry to PREAMBLE, so the first output bit is 1.
- Underrun:
  - Condition: in PAYLOAD, the shift register is empty, the last byte has not been seen, and s_axis_tvalid=0 at the moment a bit is needed.
  - Response: o_underrun pulses once per starvation episode and m_axis_tvalid drops until a byte arrives. No abort; CRC and stuffing state are held.
- Inputs are ignored outside IDLE/PAYLOAD: s_axis_tready=0.
- Zero-length frames are impossible; the first byte always exists.
- Latency: IDLE to first m_axis_tvalid is 1 cycle. At sustained m_axis_tready=1 the throughput is 1 bit/cycle.
- Frame bit count = PAR_PREAMBLE_LEN + 8 + 8N + S + 16 + 8, where N is the number of payload bytes and S is the number of stuffed bits.

Test Plan:
- Basic frame, PAR_NRZI=0, payload "123456789" (0x31..0x39), ready always high:
  - 128 bits total: 24 zeros, then 0,1,1,1,1,1,1,0.
  - FCS bits match 0x6E then 0x90, LSB-first (CRC-16/X-25 = 0x906E).
  - m_axis_tlast on bit 128.
- Stuffing, PAR_NRZI=0, payload 0xFF,0xFF: a 0 is inserted after each 5th consecutive 1 (3 inserts in payload). FCS is checked against a model including its stuffing.
- Preamble with NRZI on (PAR_NRZI=1): output bits 1..24 = 1,0,1,0,…; decoding the whole stream with NRZI-inverse reproduces test 1's raw bits.
- Backpressure: random m_axis_tready (50%) on the test 1 frame -> bit sequence identical to test 1 and data stable while tvalid && !tready.
- Underrun: withhold byte 3 for 10 cycles:
  - o_underrun pulses exactly once; m_axis_tvalid stays low during the gap.
  - The final stream equals the no-gap stream.
- Reset mid-frame: assert i_rst_n=0 during PAYLOAD, then release.
  - All outputs are 0 and o_busy=0.
  - The next frame starts with a fresh preamble and a correct FCS.
